alu_issue_stage: RTL and testbench

- Registered decode/issue stage that drives the ALU control interface (operand_a, operand_b, alu_control) from RV32I instructions.
- Accepts one instruction plus register-file read data per valid/ready handshake, decodes it, and presents a registered ALU request downstream.
- A 2-entry skid buffer gives full throughput under backpressure.
- Sits between register-read and the execute stage that instantiates the ALU.

---
 rtl/alu_issue_stage.sv | 191 +++++++++++++++++++
 tb/tb_alu_issue_stage.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_issue_stage.sv
// RV32I decode/issue stage feeding the ALU, with a 2-entry skid buffer for full throughput.
// Optional illegal-encoding flag output enabled by defining ALU_ISSUE_ILLEGAL_CHECK_EN.
//   state   | meaning
//   ST_PASS | skid empty, in_ready=1, accepts go to the output register when it is free
//   ST_FULL | skid holds the entry behind the stalled output register, in_ready=0
module alu_issue_stage #(
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [31:0]           in_instr,
  input  logic [DATA_WIDTH-1:0] in_pc,
  input  logic [DATA_WIDTH-1:0] in_rs1_data,
  input  logic [DATA_WIDTH-1:0] in_rs2_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [3:0]            out_alu_control,
  output logic [DATA_WIDTH-1:0] out_operand_a,
  output logic [DATA_WIDTH-1:0] out_operand_b,
  output logic [4:0]            out_rd,
  output logic                  out_reg_write,
  output logic [CNT_WIDTH-1:0]  issue_count
`ifdef ALU_ISSUE_ILLEGAL_CHECK_EN
  ,
  output logic                  out_illegal
`endif
);

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] F7_BASE    = 7'b0000000;
  localparam logic [6:0] F7_ALT     = 7'b0100000;
  localparam logic [3:0] ALU_ADD    = 4'b0000;
  localparam logic [3:0] ALU_SLL    = 4'b0001;

  typedef struct packed {
    logic [3:0]            alu_control;
    logic [DATA_WIDTH-1:0] operand_a;
    logic [DATA_WIDTH-1:0] operand_b;
    logic [4:0]            rd;
    logic                  reg_write;
  } entry_t;

  typedef enum logic {ST_PASS, ST_FULL} state_t;

  state_t state;
  entry_t dec, out_q, skid_q;
  logic   dec_illegal;
  logic   accept;

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;

  assign opcode = in_instr[6:0];
  assign funct3 = in_instr[14:12];
  assign funct7 = in_instr[31:25];
  assign accept = in_valid & in_ready;

  always_comb begin
    dec             = '0;
    dec.rd          = in_instr[11:7];
    dec_illegal     = 1'b0;
    case (opcode)
      OPC_OP: begin
        dec.alu_control = {funct7[5], funct3};
        dec.operand_a   = in_rs1_data;
        dec.operand_b   = in_rs2_data;
        dec.reg_write   = 1'b1;
        if (funct7 != F7_BASE && funct7 != F7_ALT)
          dec_illegal = 1'b1;
        else if (funct7 == F7_ALT && funct3 != 3'b000 && funct3 != 3'b101)
          dec_illegal = 1'b1;
      end
      OPC_OP_IMM: begin
        dec.operand_a = in_rs1_data;
        dec.operand_b = {{(DATA_WIDTH-12){in_instr[31]}}, in_instr[31:20]};
        dec.reg_write = 1'b1;
        if (funct3 == 3'b101) begin
          dec.alu_control = {funct7[5], 3'b101};
          dec.operand_b   = {{(DATA_WIDTH-5){1'b0}}, in_instr[24:20]};
          dec_illegal     = (funct7 != F7_BASE && funct7 != F7_ALT);
        end else if (funct3 == 3'b001) begin
          dec.alu_control = ALU_SLL;
          dec_illegal     = (funct7 != F7_BASE);
        end else begin
          // funct7[5] is immediate data here, so ADDI can never turn into SUB
          dec.alu_control = {1'b0, funct3};
        end
      end
      OPC_LUI: begin
        dec.alu_control = ALU_ADD;
        dec.operand_b   = {in_instr[31:12], 12'b0};
        dec.reg_write   = 1'b1;
      end
      OPC_AUIPC: begin
        dec.alu_control = ALU_ADD;
        dec.operand_a   = in_pc;
        dec.operand_b   = {in_instr[31:12], 12'b0};
        dec.reg_write   = 1'b1;
      end
      default: dec_illegal = 1'b1;
    endcase
    // Illegal or unsupported encodings still flow downstream as bubbles
    if (dec_illegal) begin
      dec.alu_control = ALU_ADD;
      dec.operand_a   = '0;
      dec.operand_b   = '0;
      dec.reg_write   = 1'b0;
    end
    if (dec.rd == 5'd0)
      dec.reg_write = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_PASS;
      in_ready    <= 1'b1;
      out_valid   <= 1'b0;
      out_q       <= '0;
      skid_q      <= '0;
      issue_count <= '0;
    end else begin
      if (out_valid && out_ready)
        issue_count <= issue_count + CNT_WIDTH'(1);
      case (state)
        ST_PASS: begin
          if (accept) begin
            if (!out_valid || out_ready) begin
              out_q     <= dec;
              out_valid <= 1'b1;
            end else begin
              skid_q   <= dec;
              state    <= ST_FULL;
              in_ready <= 1'b0;
            end
          end else if (out_ready) begin
            out_valid <= 1'b0;
          end
        end
        ST_FULL: begin
          if (out_ready) begin
            out_q    <= skid_q;
            state    <= ST_PASS;
            in_ready <= 1'b1;
          end
        end
        default: state <= ST_PASS;
      endcase
    end
  end

`ifdef ALU_ISSUE_ILLEGAL_CHECK_EN
  logic skid_illegal;

  always_ff @(posedge clk) begin
    if (rst) begin
      out_illegal  <= 1'b0;
      skid_illegal <= 1'b0;
    end else begin
      case (state)
        ST_PASS: begin
          if (accept) begin
            if (!out_valid || out_ready)
              out_illegal <= dec_illegal;
            else
              skid_illegal <= dec_illegal;
          end
        end
        ST_FULL: begin
          if (out_ready)
            out_illegal <= skid_illegal;
        end
        default: ;
      endcase
    end
  end
`endif

  assign out_alu_control = out_q.alu_control;
  assign out_operand_a   = out_q.operand_a;
  assign out_operand_b   = out_q.operand_b;
  assign out_rd          = out_q.rd;
  assign out_reg_write   = out_q.reg_write;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Self-checking bench for alu_issue_stage: directed RV32I cases, backpressure, reset, and a random
// stream checked against a queue-based reference model.
module tb_alu_issue_stage;

  localparam logic [3:0] C_ADD = 4'b0000, C_SUB = 4'b1000, C_SLL = 4'b0001, C_SLT = 4'b0010;
  localparam logic [3:0] C_SLTU = 4'b0011, C_XOR = 4'b0100, C_SRL = 4'b0101, C_SRA = 4'b1101;
  localparam logic [3:0] C_OR = 4'b0110, C_AND = 4'b0111;

  typedef struct packed {
    logic [3:0]  code;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  rd;
    logic        rw;
    logic        ill;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_instr = '0;
  logic [31:0] in_pc = '0;
  logic [31:0] in_rs1_data = '0;
  logic [31:0] in_rs2_data = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [3:0]  out_alu_control;
  logic [31:0] out_operand_a;
  logic [31:0] out_operand_b;
  logic [4:0]  out_rd;
  logic        out_reg_write;
  logic [7:0]  issue_count;
`ifdef ALU_ISSUE_ILLEGAL_CHECK_EN
  logic        out_illegal;
`endif

  int errors = 0;
  int checks = 0;
  exp_t q[$];
  int unsigned exp_count = 0;

  alu_issue_stage #(.DATA_WIDTH(32), .CNT_WIDTH(8)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
    .in_rs1_data(in_rs1_data), .in_rs2_data(in_rs2_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_alu_control(out_alu_control),
    .out_operand_a(out_operand_a), .out_operand_b(out_operand_b), .out_rd(out_rd),
    .out_reg_write(out_reg_write), .issue_count(issue_count)
`ifdef ALU_ISSUE_ILLEGAL_CHECK_EN
    , .out_illegal(out_illegal)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference decode written from the instruction-set rules, mnemonic by mnemonic
  function automatic exp_t model(input logic [31:0] instr, input logic [31:0] pc,
                                 input logic [31:0] rs1, input logic [31:0] rs2);
    exp_t e;
    logic [3:0] base [8];
    int imm;
    logic [2:0] f3;
    logic [6:0] f7;
    base = '{C_ADD, C_SLL, C_SLT, C_SLTU, C_XOR, C_SRL, C_OR, C_AND};
    f3 = instr[14:12];
    f7 = instr[31:25];
    e = '0;
    e.rd = instr[11:7];
    case (instr[6:0])
      7'h33: begin
        e.code = base[f3];
        if (f7 == 7'h20 && f3 == 3'd0) e.code = C_SUB;
        if (f7 == 7'h20 && f3 == 3'd5) e.code = C_SRA;
        e.a = rs1; e.b = rs2; e.rw = 1'b1;
        e.ill = !(f7 == 7'h00 || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5)));
      end
      7'h13: begin
        imm = int'(instr[31:20]);
        if (imm > 2047) imm = imm - 4096;
        e.a = rs1; e.b = imm; e.rw = 1'b1;
        e.code = base[f3];
        if (f3 == 3'd5) begin
          e.code = (f7 == 7'h20) ? C_SRA : C_SRL;
          e.b = int'(instr[24:20]);
        end
        e.ill = (f3 == 3'd1 && f7 != 7'h00) || (f3 == 3'd5 && f7 != 7'h00 && f7 != 7'h20);
      end
      7'h37: begin e.code = C_ADD; e.a = 0;  e.b = instr & 32'hFFFFF000; e.rw = 1'b1; end
      7'h17: begin e.code = C_ADD; e.a = pc; e.b = instr & 32'hFFFFF000; e.rw = 1'b1; end
      default: e.ill = 1'b1;
    endcase
    if (e.ill) begin e.code = C_ADD; e.a = 0; e.b = 0; e.rw = 1'b0; end
    if (e.rd == 5'd0) e.rw = 1'b0;
    return e;
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [31:0] r;
    logic [6:0]  bad [7];
    int k;
    r = $urandom;
    bad = '{7'h03, 7'h23, 7'h63, 7'h6f, 7'h67, 7'h73, 7'h0f};
    k = $urandom_range(0, 5);
    case (k)
      0, 5: return {((r[14:12] == 3'd0 || r[14:12] == 3'd5) && r[30]) ? 7'h20 : 7'h00, r[24:7], 7'h33};
      1: begin
        if (r[14:12] == 3'd1) return {7'h00, r[24:7], 7'h13};
        if (r[14:12] == 3'd5) return {r[30] ? 7'h20 : 7'h00, r[24:7], 7'h13};
        return {r[31:7], 7'h13};
      end
      2: return {r[31:7], 7'h37};
      3: return {r[31:7], 7'h17};
      default: return {r[31:7], bad[$urandom_range(0, 6)]};
    endcase
  endfunction

  // One clock: book handshakes into the model, clock, then check against the model
  task automatic tick();
    logic rst_now;
    rst_now = rst;
    if (rst_now) begin
      q.delete();
      exp_count = 0;
    end else begin
      if (out_valid && out_ready) begin
        if (q.size() > 0) void'(q.pop_front());
        exp_count = (exp_count + 1) % 256;
      end
      if (in_valid && in_ready) q.push_back(model(in_instr, in_pc, in_rs1_data, in_rs2_data));
    end
    @(posedge clk);
    #1;
    if (rst_now) begin
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_in_ready", 32'(in_ready), 32'd1);
    end
    chk("issue_count", 32'(issue_count), exp_count);
    if (out_valid) begin
      chk("no_stale_entry", {31'b0, q.size() > 0}, 32'd1);
      if (q.size() > 0) begin
        chk("alu_control", 32'(out_alu_control), 32'(q[0].code));
        chk("operand_a", out_operand_a, q[0].a);
        chk("operand_b", out_operand_b, q[0].b);
        chk("rd", 32'(out_rd), 32'(q[0].rd));
        chk("reg_write", 32'(out_reg_write), 32'(q[0].rw));
`ifdef ALU_ISSUE_ILLEGAL_CHECK_EN
        chk("illegal", 32'(out_illegal), 32'(q[0].ill));
`endif
      end
    end
  endtask

  task automatic drive(input logic v, input logic [31:0] instr, input logic [31:0] pc,
                       input logic [31:0] rs1, input logic [31:0] rs2);
    in_valid = v; in_instr = instr; in_pc = pc; in_rs1_data = rs1; in_rs2_data = rs2;
  endtask

  task automatic issue_check(input string tag, input logic [31:0] instr, input logic [31:0] pc,
                             input logic [31:0] rs1, input logic [31:0] rs2,
                             input logic [3:0] code, input logic [31:0] a, input logic [31:0] b,
                             input logic rw);
    out_ready = 1'b1;
    drive(1'b1, instr, pc, rs1, rs2);
    tick();
    chk({tag, "_valid"}, 32'(out_valid), 32'd1);
    chk({tag, "_code"}, 32'(out_alu_control), 32'(code));
    chk({tag, "_a"}, out_operand_a, a);
    chk({tag, "_b"}, out_operand_b, b);
    chk({tag, "_rw"}, 32'(out_reg_write), 32'(rw));
    in_valid = 1'b0;
    tick();
  endtask

  function automatic logic [31:0] r_type(input logic [6:0] f7, input logic [4:0] rs2,
                                         input logic [4:0] rs1, input logic [2:0] f3,
                                         input logic [4:0] rd);
    return {f7, rs2, rs1, f3, rd, 7'h33};
  endfunction

  initial begin
    rst = 1'b1;
    tick();
    tick();
    chk("rst_count", 32'(issue_count), 32'd0);
    chk("rst_alu_control", 32'(out_alu_control), 32'd0);
    chk("rst_operand_a", out_operand_a, 32'd0);
    chk("rst_operand_b", out_operand_b, 32'd0);
`ifdef ALU_ISSUE_ILLEGAL_CHECK_EN
    chk("rst_illegal", 32'(out_illegal), 32'd0);
`endif
    rst = 1'b0;
    tick();

    issue_check("add", r_type(7'h00, 5'd2, 5'd1, 3'd0, 5'd3), 0, 5, 3, C_ADD, 5, 3, 1'b1);
    chk("add_rd", 32'(issue_count), 32'd1);
    issue_check("srai", {7'h20, 5'd4, 5'd6, 3'b101, 5'd5, 7'h13}, 0, 32'h80000000, 7,
                C_SRA, 32'h80000000, 32'h4, 1'b1);
    issue_check("addi", {12'hFFF, 5'd0, 3'b000, 5'd1, 7'h13}, 0, 0, 0, C_ADD, 0, 32'hFFFFFFFF, 1'b1);
    issue_check("lui", {20'h12345, 5'd7, 7'h37}, 0, 9, 9, C_ADD, 0, 32'h12345000, 1'b1);
    issue_check("auipc", {20'h00001, 5'd8, 7'h17}, 32'h1000, 9, 9, C_ADD, 32'h1000, 32'h1000, 1'b1);
    issue_check("add_x0", r_type(7'h00, 5'd2, 5'd1, 3'd0, 5'd0), 0, 5, 3, C_ADD, 5, 3, 1'b0);
    issue_check("load_bubble", {12'h0, 5'd1, 3'b010, 5'd9, 7'h03}, 0, 5, 3, C_ADD, 0, 0, 1'b0);
`ifdef ALU_ISSUE_ILLEGAL_CHECK_EN
    drive(1'b1, {12'h0, 5'd1, 3'b010, 5'd9, 7'h03}, 0, 5, 3);
    tick();
    chk("load_illegal", 32'(out_illegal), 32'd1);
    chk("load_illegal_rw", 32'(out_reg_write), 32'd0);
    in_valid = 1'b0;
    tick();
`endif
    chk("directed_count", 32'(issue_count), 32'(exp_count));

    // Backpressure: SUB in output, XOR in skid, third held upstream
    out_ready = 1'b0;
    drive(1'b1, r_type(7'h20, 5'd2, 5'd1, 3'd0, 5'd4), 0, 10, 3);
    tick();
    chk("bp_sub_code", 32'(out_alu_control), 32'(C_SUB));
    drive(1'b1, r_type(7'h00, 5'd2, 5'd1, 3'd4, 5'd5), 0, 32'hF0, 32'h0F);
    tick();
    chk("bp_skid_in_ready", 32'(in_ready), 32'd0);
    drive(1'b1, r_type(7'h00, 5'd2, 5'd1, 3'd7, 5'd6), 0, 32'hFF, 32'h3C);
    tick();
    tick();
    chk("bp_hold_code", 32'(out_alu_control), 32'(C_SUB));
    chk("bp_hold_ready", 32'(in_ready), 32'd0);
    out_ready = 1'b1;
    tick();
    chk("bp_xor_code", 32'(out_alu_control), 32'(C_XOR));
    chk("bp_release_ready", 32'(in_ready), 32'd1);
    tick();
    chk("bp_and_code", 32'(out_alu_control), 32'(C_AND));
    in_valid = 1'b0;
    tick();
    chk("bp_drained", 32'(out_valid), 32'd0);

    // Reset while FULL discards both entries
    out_ready = 1'b0;
    drive(1'b1, rand_instr(), $urandom, $urandom, $urandom);
    tick();
    drive(1'b1, rand_instr(), $urandom, $urandom, $urandom);
    tick();
    in_valid = 1'b0;
    chk("full_in_ready", 32'(in_ready), 32'd0);
    rst = 1'b1;
    tick();
    chk("rst_full_count", 32'(issue_count), 32'd0);
    rst = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rst_no_stale", 32'(out_valid), 32'd0);
    end

    // 300 back-to-back issues; 8-bit count wraps to 44
    for (int i = 0; i < 300; i++) begin
      drive(1'b1, rand_instr(), $urandom, $urandom, $urandom);
      tick();
      chk("stream_valid", 32'(out_valid), 32'd1);
      chk("stream_ready", 32'(in_ready), 32'd1);
    end
    in_valid = 1'b0;
    tick();
    chk("stream_count", 32'(issue_count), 32'd44);

    // Random valid/ready mix
    for (int i = 0; i < 400; i++) begin
      drive(1'($urandom_range(0, 1)), rand_instr(), $urandom, $urandom, $urandom);
      out_ready = 1'($urandom_range(0, 3) != 0);
      tick();
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    chk("final_empty", 32'(q.size()), 32'd0);
    chk("final_valid", 32'(out_valid), 32'd0);
    chk("final_count", 32'(issue_count), exp_count);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
